// File: rtl/pipe_skid_stage_pkg.sv
// Shared pipeline definitions for the skid-buffered stage.
package pipe_skid_stage_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam int unsigned OCC_W = 2;

endpackage

// File: rtl/pipe_skid_stage_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry skid stage: registered in_ready, flush-to-bubble, starvation counter.
module pipe_skid_stage
  import pipe_skid_stage_pkg::*;
#(
  parameter int unsigned      WIDTH       = 32,
  parameter logic [WIDTH-1:0] DEFAULT_VAL = '0,
  parameter int unsigned      CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [OCC_W-1:0] occupancy,
  output logic [CNT_W-1:0] starve_cnt
);

  state_t           state, state_nx;
  logic [WIDTH-1:0] main_q, main_nx;
  logic [WIDTH-1:0] skid_q, skid_nx;
  logic             in_fire, out_fire;

  // Handshake outputs depend on state only, so there is no ready/valid loop.
  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      main_q <= DEFAULT_VAL;
      skid_q <= DEFAULT_VAL;
    end else begin
      state  <= state_nx;
      main_q <= main_nx;
      skid_q <= skid_nx;
    end
  end

  always_comb begin
    state_nx = state;
    main_nx  = main_q;
    skid_nx  = skid_q;
    if (flush) begin
      state_nx = EMPTY;
      main_nx  = DEFAULT_VAL;
      skid_nx  = DEFAULT_VAL;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_fire) begin
            main_nx  = in_data;
            state_nx = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_nx = in_data;
          end else if (in_fire) begin
            skid_nx  = in_data;
            state_nx = TWO;
          end else if (out_fire) begin
            main_nx  = DEFAULT_VAL;
            state_nx = EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            main_nx  = skid_q;
            skid_nx  = DEFAULT_VAL;
            state_nx = ONE;
          end
        end
        default: begin
          state_nx = EMPTY;
          main_nx  = DEFAULT_VAL;
          skid_nx  = DEFAULT_VAL;
        end
      endcase
    end
  end

  always_comb begin
    occupancy = '0;
    unique case (state)
      EMPTY:   occupancy = OCC_W'(0);
      ONE:     occupancy = OCC_W'(1);
      TWO:     occupancy = OCC_W'(2);
      default: occupancy = '0;
    endcase
  end

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_starve (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (out_ready & ~out_valid),
    .count (starve_cnt)
  );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Scoreboard bench: stimulus pushes accepted beats, monitor checks outputs against a FIFO model.
module tb_pipe_skid_stage;

  localparam logic [15:0] DEF1 = 16'hDEAD;
  localparam logic [7:0]  DEF2 = 8'h5A;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, out_ready, flush;
  logic [15:0] in_data;
  logic        in_ready, out_valid;
  logic [15:0] out_data;
  logic [1:0]  occupancy;
  logic [15:0] starve_cnt;
  logic        in_ready2, out_valid2;
  logic [7:0]  out_data2;
  logic [1:0]  occupancy2;
  logic [1:0]  starve_cnt2;

  logic [15:0] q[$];
  int unsigned sc1, sc2;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  pipe_skid_stage #(
    .WIDTH       (16),
    .DEFAULT_VAL (DEF1),
    .CNT_W       (16)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .occupancy  (occupancy),
    .starve_cnt (starve_cnt)
  );

  pipe_skid_stage #(
    .WIDTH       (8),
    .DEFAULT_VAL (DEF2),
    .CNT_W       (2)
  ) u_dut2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready2),
    .in_data    (in_data[7:0]),
    .flush      (flush),
    .out_valid  (out_valid2),
    .out_ready  (out_ready),
    .out_data   (out_data2),
    .occupancy  (occupancy2),
    .starve_cnt (starve_cnt2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; accepted beats enter the scoreboard just before the edge.
  task automatic cyc(input logic v, input logic [15:0] d, input logic r, input logic f);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    #3;
    if (rst_n && in_valid && in_ready && !flush) q.push_back(in_data);
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    q.delete();
    sc1 = 0;
    sc2 = 0;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_starve", 32'(starve_cnt), 32'd0);
    chk("async_rst_starve2", 32'(starve_cnt2), 32'd0);
    cyc(1'b1, 16'h0077, 1'b1, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Monitor: compares visible outputs with the model, then retires fired/flushed beats.
  initial begin
    logic        exp_valid;
    logic [15:0] exp_data;
    forever begin
      @(negedge clk);
      #2;
      exp_valid = (q.size() != 0);
      exp_data  = exp_valid ? q[0] : DEF1;
      chk("out_valid", 32'(out_valid), 32'(exp_valid));
      chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
      chk("occupancy", 32'(occupancy), 32'(q.size()));
      chk("out_data", 32'(out_data), 32'(exp_data));
      chk("starve_cnt", 32'(starve_cnt), sc1);
      chk("out_valid2", 32'(out_valid2), 32'(exp_valid));
      chk("in_ready2", 32'(in_ready2), 32'(q.size() < 2));
      chk("occupancy2", 32'(occupancy2), 32'(q.size()));
      chk("out_data2", 32'(out_data2), 32'(exp_valid ? exp_data[7:0] : DEF2));
      chk("starve_cnt2", 32'(starve_cnt2), sc2);
      if (rst_n) begin
        if (out_ready === 1'b1) begin
          if (q.size() == 0) begin
            if (sc1 < 65535) sc1++;
            if (sc2 < 3) sc2++;
          end else begin
            void'(q.pop_front());
          end
        end
        if (flush === 1'b1) q.delete();
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    sc1       = 0;
    sc2       = 0;
    repeat (2) cyc(1'b0, 16'h0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Starvation with saturation on the narrow counter: 1,2,3,3,3,3.
    repeat (6) cyc(1'b0, 16'h0, 1'b1, 1'b0);
    cyc(1'b1, 16'h0011, 1'b1, 1'b0);
    cyc(1'b0, 16'h0, 1'b1, 1'b0);
    for (int i = 1; i <= 8; i++) cyc(1'b1, 16'(i), 1'b1, 1'b0);
    repeat (2) cyc(1'b0, 16'h0, 1'b1, 1'b0);

    // Back-pressure fills the skid, then drains in order.
    cyc(1'b1, 16'h000A, 1'b0, 1'b0);
    cyc(1'b1, 16'h000B, 1'b0, 1'b0);
    repeat (2) cyc(1'b1, 16'h00EE, 1'b0, 1'b0);
    repeat (3) cyc(1'b0, 16'h0, 1'b1, 1'b0);

    // Flush in TWO with a competing beat.
    cyc(1'b1, 16'h000A, 1'b0, 1'b0);
    cyc(1'b1, 16'h000B, 1'b0, 1'b0);
    cyc(1'b1, 16'h000C, 1'b0, 1'b1);
    repeat (2) cyc(1'b0, 16'h0, 1'b1, 1'b0);

    // Flush while an output fires and input is offered.
    cyc(1'b1, 16'h0021, 1'b0, 1'b0);
    cyc(1'b1, 16'h0022, 1'b0, 1'b0);
    cyc(1'b1, 16'h0023, 1'b1, 1'b1);
    repeat (2) cyc(1'b0, 16'h0, 1'b1, 1'b0);

    // Asynchronous reset while holding one beat; first beat after release is taken.
    cyc(1'b1, 16'h0033, 1'b0, 1'b0);
    mid_reset();
    cyc(1'b1, 16'h0044, 1'b1, 1'b0);
    cyc(1'b0, 16'h0, 1'b0, 1'b0);
    cyc(1'b0, 16'h0, 1'b1, 1'b0);

    for (int n = 0; n < 3000; n++) begin
      cyc(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 99) < 60),
          1'($urandom_range(0, 15) == 0));
    end
    repeat (4) cyc(1'b0, 16'h0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 Parameter WIDTH, default 32: payload width in bits.
REQ-002 Parameter DEFAULT_VAL, default 0 (WIDTH bits): payload driven when the stage is empty or flushed.
REQ-003 Parameter CNT_W, default 16: width of the starvation counter.
REQ-004 clk  input  1: single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1: asynchronous, active-low reset.
REQ-006 in_valid  input  1: upstream beat present.
REQ-007 in_ready  output  1: stage can accept a beat this cycle.
REQ-008 in_data  input  WIDTH: upstream payload.
REQ-009 flush  input  1: discard all held beats (bubble insertion).
REQ-010 out_valid  output  1: downstream beat present.
REQ-011 out_ready  input  1: downstream accepts the beat.
REQ-012 out_data  output  WIDTH: downstream payload.
REQ-013 occupancy  output  2: number of held beats, 0..2.
REQ-014 starve_cnt  output  CNT_W: count of cycles with out_ready=1 and out_valid=0.

Function
REQ-015 Input fire = in_valid & in_ready; output fire = out_valid & out_ready.
REQ-016 The stage has three states: EMPTY (0 beats), ONE (main register full), TWO (main and skid registers full).
REQ-017 in_ready = (state != TWO), decoded from state only, with no combinational path from out_ready or in_valid.
REQ-018 out_valid = (state != EMPTY).
REQ-019 out_data = main register; the main register holds DEFAULT_VAL whenever the state is EMPTY.
REQ-020 EMPTY: on input fire, main <= in_data and go to ONE; otherwise stay in EMPTY.
REQ-021 ONE: on input fire with output fire, main <= in_data and stay in ONE.
REQ-022 ONE: on input fire only, skid <= in_data and go to TWO.
REQ-023 ONE: on output fire only, main <= DEFAULT_VAL and go to EMPTY.
REQ-024 TWO: on output fire, main <= skid, skid <= DEFAULT_VAL, and go to ONE; no input is accepted in TWO.
REQ-025 Latency: the first beat into EMPTY is visible on out_data the next cycle; throughput is 1 beat/cycle while out_ready=1.
REQ-026 Ordering: beats leave strictly in acceptance order; there is no loss or duplication without flush.
REQ-027 When out_valid=1 and out_ready=0, out_data and out_valid hold stable.
REQ-028 flush has highest priority: next state EMPTY, main and skid <= DEFAULT_VAL, and any beat input-fired in the same cycle is dropped.
REQ-029 An output fire in the flush cycle counts as delivered; the beat behind it is discarded.
REQ-030 occupancy = 0/1/2 for EMPTY/ONE/TWO.
REQ-031 starve_cnt increments by 1 in each cycle with out_ready=1 and out_valid=0, and saturates at 2^CNT_W-1 (no wrap).
REQ-032 flush does not clear starve_cnt.

Reset
REQ-033 While rst_n=0, the stage holds: state EMPTY, main = skid = DEFAULT_VAL, starve_cnt = 0.
REQ-034 Resulting outputs during reset: out_valid=0, in_ready=1, occupancy=0, out_data=DEFAULT_VAL.
REQ-035 Reset asserted mid-operation clears the stage immediately, without waiting for a clock edge, and all held beats are lost.
REQ-036 The first input fire is honoured on the first rising edge after rst_n deasserts.

Structure
REQ-037 The shared pipeline package holds the state enum (EMPTY/ONE/TWO) and the occupancy width constant.
REQ-038 The saturating counter is a sub-module named sat_counter, parametrised by width, with inc, async active-low reset, and count out.
REQ-039 The stage is instantiable for any WIDTH >= 1, with no internal width truncation.

Verification
REQ-040 Reset then in_valid=1, in_data=0x11, out_ready=1 -> next cycle out_valid=1, out_data=0x11, occupancy=1.
REQ-041 Stream 0x1..0x8 with out_ready=1 every cycle -> outputs 0x1..0x8 on consecutive cycles, in_ready never 0.
REQ-042 out_ready=0 while sending 0xA then 0xB -> occupancy=2, in_ready=0, out_data=0xA held; then out_ready=1 -> 0xA, then 0xB, then EMPTY.
REQ-043 State TWO (0xA, 0xB) with flush=1 and in_valid=1 carrying 0xC -> next cycle occupancy=0, out_data=DEFAULT_VAL, and 0xC never appears.
REQ-044 CNT_W=2, out_ready=1 with no input for 6 cycles -> starve_cnt goes 1, 2, 3, 3, 3, 3.
REQ-045 rst_n pulled low mid-cycle in state ONE -> out_valid=0 and starve_cnt=0 before the next clock edge.
